load_hazard_ctrl: RTL and testbench

//  Parametrised load-use hazard and control-flush unit for the 5-stage MIPS pipeline; ID-stage control block.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/load_hazard_ctrl_scoreboard.sv | 78 +++++++
 rtl/load_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_load_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and scoreboard entry type for the ID-stage hazard unit.
// Load/store/idle memory-control codes, write-back select, entry struct.
package hazard_pkg;

  localparam logic [1:0] DMC_LOAD  = 2'b00;
  localparam logic [1:0] DMC_STORE = 2'b01;
  localparam logic [1:0] DMC_IDLE  = 2'b11;

  localparam logic WB_SEL_MEM = 1'b0;

  // Entries hold addresses zero-extended to this width,
  // so any ADDR_W up to SB_ADDR_MAX shares one type.
  localparam int SB_ADDR_MAX = 8;

  typedef struct packed {
    logic                   valid;
    logic [SB_ADDR_MAX-1:0] addr;
  } sb_entry_t;

  function automatic logic is_load(
    input logic       we,
    input logic [1:0] dmc,
    input logic       wb
  );
    return we & (dmc == DMC_LOAD) & (wb == WB_SEL_MEM);
  endfunction

endpackage

// File: rtl/load_hazard_ctrl_scoreboard.sv
// In-flight load scoreboard: slot 0 is the EX load, older slots are registered.
// Ports: clk, rst, load_i, rd_addr_i, rs/rt addr+used in; rs_hit_o, rt_hit_o out.
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic              rs_used_i,
  input  logic              rt_used_i,
  output logic              rs_hit_o,
  output logic              rt_hit_o
);

  sb_entry_t                slot0;
  sb_entry_t [LOAD_LAT-1:0] live;

  logic [SB_ADDR_MAX-1:0] rs_ext;
  logic [SB_ADDR_MAX-1:0] rt_ext;
  logic                   rs_any;
  logic                   rt_any;
  logic                   rs_zero;
  logic                   rt_zero;

  assign slot0.valid = load_i;
  assign slot0.addr  = SB_ADDR_MAX'(rd_addr_i);

  // Older slots shift every cycle regardless of a stall:
  // everything past ID keeps moving.
  if (LOAD_LAT > 1) begin : g_hist
    sb_entry_t [LOAD_LAT-2:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist_q <= '0;
      end else begin
        hist_q[0] <= slot0;
        for (int k = 1; k < LOAD_LAT - 1; k++) begin
          hist_q[k] <= hist_q[k-1];
        end
      end
    end

    assign live = {hist_q, slot0};
  end else begin : g_nohist
    assign live = slot0;
  end

  assign rs_ext = SB_ADDR_MAX'(rs_addr_i);
  assign rt_ext = SB_ADDR_MAX'(rt_addr_i);

  always_comb begin
    rs_any = 1'b0;
    rt_any = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (live[k].valid && (live[k].addr == rs_ext)) begin
        rs_any = 1'b1;
      end
      if (live[k].valid && (live[k].addr == rt_ext)) begin
        rt_any = 1'b1;
      end
    end
  end

  assign rs_zero = (ZERO_REG != 0) && (rs_addr_i == '0);
  assign rt_zero = (ZERO_REG != 0) && (rt_addr_i == '0);

  assign rs_hit_o = rs_used_i & ~rs_zero & rs_any;
  assign rt_hit_o = rt_used_i & ~rt_zero & rt_any;

endmodule

// File: rtl/load_hazard_ctrl.sv
// Load-use stall / branch flush control for the ID stage, with perf counters.
// In: EX load info, ID sources, BranchTaken_EX, perf_clr. Out: stall/flush/enables, counters.
module load_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RDaddr_EX,
  input  logic              WE_EX,
  input  logic [1:0]        DMC_EX,
  input  logic              WBmux_EX,
  input  logic [ADDR_W-1:0] RSaddr_ID,
  input  logic [ADDR_W-1:0] RTaddr_ID,
  input  logic              RSused_ID,
  input  logic              RTused_ID,
  input  logic              BranchTaken_EX,
  input  logic              perf_clr,
  output logic              Stall,
  output logic              PC_EN,
  output logic              IFID_EN,
  output logic              IFID_FLUSH,
  output logic              IDEX_FLUSH,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic load_ex;
  logic rs_hit;
  logic rt_hit;
  logic hazard;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  assign load_ex = is_load(WE_EX, DMC_EX, WBmux_EX);

  load_scoreboard #(
    .ADDR_W  (ADDR_W),
    .LOAD_LAT(LOAD_LAT),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_ex),
    .rd_addr_i(RDaddr_EX),
    .rs_addr_i(RSaddr_ID),
    .rt_addr_i(RTaddr_ID),
    .rs_used_i(RSused_ID),
    .rt_used_i(RTused_ID),
    .rs_hit_o (rs_hit),
    .rt_hit_o (rt_hit)
  );

  assign hazard = rs_hit | rt_hit;

  // A taken branch beats the hazard: the ID instruction
  // is wrong-path, so stalling for it would waste a cycle.
  always_comb begin
    Stall      = 1'b0;
    PC_EN      = 1'b1;
    IFID_EN    = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    priority case (1'b1)
      rst: begin
      end
      BranchTaken_EX: begin
        IFID_FLUSH = 1'b1;
        IDEX_FLUSH = 1'b1;
      end
      hazard: begin
        Stall      = 1'b1;
        PC_EN      = 1'b0;
        IFID_EN    = 1'b0;
        IDEX_FLUSH = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (Stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (IFID_FLUSH && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// Bench for load_hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances vs a load-age model.
// Directed scenarios first, then randomized traffic with resets and counter clears.
module tb_load_hazard_ctrl;

  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rd;
  logic          we;
  logic [1:0]    dmc;
  logic          wb;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic          rsu;
  logic          rtu;
  logic          br;
  logic          clr;

  logic          st1, pc1, ife1, iff1, idf1;
  logic          st3, pc3, ife3, iff3, idf3;
  logic [CW-1:0] sc1, fc1, sc3, fc3;

  load_hazard_ctrl #(
    .ADDR_W(AW), .LOAD_LAT(1), .CNT_W(CW), .ZERO_REG(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .RDaddr_EX(rd), .WE_EX(we), .DMC_EX(dmc), .WBmux_EX(wb),
    .RSaddr_ID(rs), .RTaddr_ID(rt),
    .RSused_ID(rsu), .RTused_ID(rtu),
    .BranchTaken_EX(br), .perf_clr(clr),
    .Stall(st1), .PC_EN(pc1), .IFID_EN(ife1),
    .IFID_FLUSH(iff1), .IDEX_FLUSH(idf1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  load_hazard_ctrl #(
    .ADDR_W(AW), .LOAD_LAT(3), .CNT_W(CW), .ZERO_REG(1)
  ) dut3 (
    .clk(clk), .rst(rst),
    .RDaddr_EX(rd), .WE_EX(we), .DMC_EX(dmc), .WBmux_EX(wb),
    .RSaddr_ID(rs), .RTaddr_ID(rt),
    .RSused_ID(rsu), .RTused_ID(rtu),
    .BranchTaken_EX(br), .perf_clr(clr),
    .Stall(st3), .PC_EN(pc3), .IFID_EN(ife3),
    .IFID_FLUSH(iff3), .IDEX_FLUSH(idf3),
    .stall_cnt(sc3), .flush_cnt(fc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: list of loads with the cycle they sat in EX.
  typedef struct {
    int addr;
    int cyc;
  } ld_t;

  ld_t q[$];
  int  now;
  int  msc[2];
  int  mfc[2];

  function automatic bit dep(int lat, bit ld, int a, bit used);
    if (!used || a == 0) return 1'b0;
    if (ld && int'(rd) == a) return 1'b1;
    foreach (q[i]) begin
      if ((now - q[i].cyc) < lat && q[i].addr == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [4:0] exp_ctl(bit r, bit b, bit hz);
    if (r) return 5'b01100;
    if (b) return 5'b01111;
    if (hz) return 5'b10001;
    return 5'b01100;
  endfunction

  task automatic cycle();
    bit ld;
    bit hz[2];
    int lat[2];
    logic [4:0] e[2];
    lat[0] = 1;
    lat[1] = 3;
    @(negedge clk);
    ld = we && (dmc == 2'b00) && (wb == 1'b0);
    if (rst) begin
      q.delete();
      msc = '{0, 0};
      mfc = '{0, 0};
    end
    for (int d = 0; d < 2; d++) begin
      hz[d] = dep(lat[d], ld, int'(rs), rsu) | dep(lat[d], ld, int'(rt), rtu);
      e[d]  = exp_ctl(rst, br, hz[d]);
    end
    chk("ctl_lat1", {27'd0, st1, pc1, ife1, iff1, idf1}, {27'd0, e[0]});
    chk("ctl_lat3", {27'd0, st3, pc3, ife3, iff3, idf3}, {27'd0, e[1]});
    chk("stall_cnt_lat1", {28'd0, sc1}, msc[0]);
    chk("stall_cnt_lat3", {28'd0, sc3}, msc[1]);
    chk("flush_cnt_lat1", {28'd0, fc1}, mfc[0]);
    chk("flush_cnt_lat3", {28'd0, fc3}, mfc[1]);
    @(posedge clk);
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (clr) begin
          msc[d] = 0;
          mfc[d] = 0;
        end else begin
          if (e[d][4] && msc[d] < CMAX) msc[d]++;
          if (e[d][1] && mfc[d] < CMAX) mfc[d]++;
        end
      end
      if (ld) q.push_back('{int'(rd), now});
    end
    now++;
    while (q.size() > 0 && (now - q[0].cyc) > 4) void'(q.pop_front());
    #1;
  endtask

  task automatic drv(bit w, logic [1:0] m, bit b, int d,
                     int s, int t, bit su, bit tu, bit bt);
    we  = w;
    dmc = m;
    wb  = b;
    rd  = AW'(d);
    rs  = AW'(s);
    rt  = AW'(t);
    rsu = su;
    rtu = tu;
    br  = bt;
  endtask

  task automatic bubble_use(int s, int n);
    for (int i = 0; i < n; i++) begin
      drv(0, 2'b11, 1, 0, s, 9, 1, 0, 0);
      cycle();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    now         = 0;
    msc         = '{0, 0};
    mfc         = '{0, 0};
    rst         = 1'b1;
    clr         = 1'b0;
    drv(0, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Back-to-back load-use on r3.
    drv(1, 2'b00, 0, 3, 3, 5, 1, 1, 0);
    cycle();
    bubble_use(3, 3);

    // Load r7, two unrelated instructions, then r7 consumer.
    drv(1, 2'b00, 0, 7, 1, 2, 1, 1, 0);
    cycle();
    drv(0, 2'b11, 1, 0, 1, 2, 1, 1, 0);
    cycle();
    bubble_use(7, 4);

    // r0 load never stalls; unused RT never stalls.
    drv(1, 2'b00, 0, 0, 0, 0, 1, 1, 0);
    cycle();
    drv(1, 2'b00, 0, 6, 1, 6, 1, 0, 0);
    cycle();
    bubble_use(0, 3);

    // Store / non-mem write-back are not loads.
    drv(1, 2'b01, 0, 4, 4, 4, 1, 1, 0);
    cycle();
    drv(1, 2'b00, 1, 4, 4, 4, 1, 1, 0);
    cycle();

    // Branch and hazard in the same cycle.
    drv(1, 2'b00, 0, 5, 5, 0, 1, 0, 1);
    cycle();
    bubble_use(9, 3);

    // Counter saturation, then a clear that coincides with a stall.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < CMAX + 3; i++) begin
      drv(1, 2'b00, 0, 3, 3, 0, 1, 0, 0);
      cycle();
    end
    clr = 1'b1;
    drv(1, 2'b00, 0, 3, 3, 0, 1, 0, 0);
    cycle();
    clr = 1'b0;
    bubble_use(0, 3);

    // Reset in the middle of a LOAD_LAT=3 stall.
    drv(1, 2'b00, 0, 7, 7, 0, 1, 0, 0);
    cycle();
    bubble_use(7, 1);
    rst = 1'b1;
    bubble_use(7, 1);
    rst = 1'b0;
    bubble_use(7, 3);

    // Randomized traffic over a small register window.
    for (int i = 0; i < 800; i++) begin
      drv($urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 3),
          $urandom_range(0, 3),
          $urandom_range(0, 3),
          $urandom_range(0, 1),
          $urandom_range(0, 1),
          $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
